ansi_cmd_parser: RTL and testbench

- Byte-stream front end for the terminal command executor.
- Decodes incoming ASCII/ANSI escape sequences (ESC, CSI) into one-hot command strobes Delete, CUF, CUB, CNL, CPL, CHA, CUP, ED, EL, SU, SD, HVP, SCP, RCP, Clear and Uname, plus decoded numeric parameters.
- Printable characters pass through on a separate character output.
- Sits between the UART receive byte interface and the command executor FSM.

---
 rtl/ansi_cmd_parser_pkg.sv | 84 ++++++++
 rtl/ansi_cmd_parser_if.sv | 29 ++
 rtl/ansi_cmd_parser_dec_param_acc.sv | 39 +++
 rtl/ansi_cmd_parser.sv | 189 ++++++++++++++++++
 tb/tb_ansi_cmd_parser.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ansi_cmd_parser_pkg.sv
// Shared constants and types for the ANSI command parser and the command executor.
package term_pkg;

  // Control and introducer bytes
  localparam logic [7:0] ESC       = 8'h1B;
  localparam logic [7:0] CSI_INTRO = 8'h5B;
  localparam logic [7:0] CAN       = 8'h18;
  localparam logic [7:0] SUB       = 8'h1A;
  localparam logic [7:0] BS        = 8'h08;
  localparam logic [7:0] DEL       = 8'h7F;
  localparam logic [7:0] SEMI      = 8'h3B;

  // Final bytes of CSI sequences
  localparam logic [7:0] FIN_CUF = 8'h43;
  localparam logic [7:0] FIN_CUB = 8'h44;
  localparam logic [7:0] FIN_CNL = 8'h45;
  localparam logic [7:0] FIN_CPL = 8'h46;
  localparam logic [7:0] FIN_CHA = 8'h47;
  localparam logic [7:0] FIN_CUP = 8'h48;
  localparam logic [7:0] FIN_ED  = 8'h4A;
  localparam logic [7:0] FIN_EL  = 8'h4B;
  localparam logic [7:0] FIN_SU  = 8'h53;
  localparam logic [7:0] FIN_SD  = 8'h54;
  localparam logic [7:0] FIN_HVP = 8'h66;
  localparam logic [7:0] FIN_SCP = 8'h73;
  localparam logic [7:0] FIN_RCP = 8'h75;

  // Bytes directly following ESC
  localparam logic [7:0] FIN_CLEAR = 8'h63;
  localparam logic [7:0] FIN_UNAME = 8'h5A;

  typedef enum logic [2:0] {
    ST_GROUND,
    ST_ESC,
    ST_CSI_P1,
    ST_CSI_P2,
    ST_CSI_IGN,
    ST_HOLD
  } parser_state_e;

  typedef enum logic [4:0] {
    CMD_NONE,
    CMD_DELETE,
    CMD_CUF,
    CMD_CUB,
    CMD_CNL,
    CMD_CPL,
    CMD_CHA,
    CMD_CUP,
    CMD_ED,
    CMD_EL,
    CMD_SU,
    CMD_SD,
    CMD_HVP,
    CMD_SCP,
    CMD_RCP,
    CMD_CLEAR,
    CMD_UNAME,
    CMD_CHAR
  } cmd_e;

  // Map a CSI final byte to its command; unknown finals give CMD_NONE
  function automatic cmd_e decode_final(input logic [7:0] b);
    cmd_e c;
    case (b)
      FIN_CUF: c = CMD_CUF;
      FIN_CUB: c = CMD_CUB;
      FIN_CNL: c = CMD_CNL;
      FIN_CPL: c = CMD_CPL;
      FIN_CHA: c = CMD_CHA;
      FIN_CUP: c = CMD_CUP;
      FIN_ED:  c = CMD_ED;
      FIN_EL:  c = CMD_EL;
      FIN_SU:  c = CMD_SU;
      FIN_SD:  c = CMD_SD;
      FIN_HVP: c = CMD_HVP;
      FIN_SCP: c = CMD_SCP;
      FIN_RCP: c = CMD_RCP;
      default: c = CMD_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ansi_cmd_parser_if.sv
// Byte-in / command-out bundle between the UART receiver, the parser and the executor.
interface ansi_cmd_parser_if #(parameter int PARAM_W = 8) ();
  logic               in_valid;
  logic [7:0]         in_data;
  logic               in_ready;
  logic               out_ready;
  logic               Delete, CUF, CUB, CNL, CPL, CHA, CUP, ED;
  logic               EL, SU, SD, HVP, SCP, RCP, Clear, Uname;
  logic [PARAM_W-1:0] par1;
  logic [PARAM_W-1:0] par2;
  logic               char_valid;
  logic [7:0]         char_data;

  // Byte source and command sink side
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, Delete, CUF, CUB, CNL, CPL, CHA, CUP, ED,
    input  EL, SU, SD, HVP, SCP, RCP, Clear, Uname,
    input  par1, par2, char_valid, char_data
  );

  // Parser side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, Delete, CUF, CUB, CNL, CPL, CHA, CUP, ED,
    output EL, SU, SD, HVP, SCP, RCP, Clear, Uname,
    output par1, par2, char_valid, char_data
  );
endinterface

// File: rtl/ansi_cmd_parser_dec_param_acc.sv
// Saturating decimal accumulator for one CSI numeric parameter, with presence flag.
module dec_param_acc #(
  parameter int PARAM_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic               i_digit_valid,
  input  logic [3:0]         i_digit,
  output logic [PARAM_W-1:0] o_value,
  output logic               o_present
);
  localparam int WIDE_W = PARAM_W + 4;
  localparam logic [WIDE_W-1:0] MAX_WIDE = {4'b0000, {PARAM_W{1'b1}}};

  logic [PARAM_W-1:0] r_value;
  logic               r_present;
  logic [WIDE_W-1:0]  w_sum;

  // Four extra bits hold max*10+9 without overflow, so the compare is exact
  assign w_sum = WIDE_W'(r_value) * WIDE_W'(10) + WIDE_W'(i_digit);

  // Clear wins over a digit; once saturated the value sticks at max
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value   <= '0;
      r_present <= 1'b0;
    end else if (i_clear) begin
      r_value   <= '0;
      r_present <= 1'b0;
    end else if (i_digit_valid) begin
      r_value   <= (w_sum > MAX_WIDE) ? {PARAM_W{1'b1}} : w_sum[PARAM_W-1:0];
      r_present <= 1'b1;
    end
  end

  assign o_value   = r_value;
  assign o_present = r_present;
endmodule

// File: rtl/ansi_cmd_parser.sv
// ANSI/CSI byte-stream decoder producing one-hot command strobes and printable characters.
module ansi_cmd_parser
  import term_pkg::*;
#(
  parameter int PARAM_W = 8
) (
  input logic              clk,
  input logic              rst,
  ansi_cmd_parser_if.slave bus
);
  localparam logic [PARAM_W-1:0] ONE = PARAM_W'(1);

  parser_state_e      r_state, w_state_next;
  cmd_e               r_cmd, w_cmd_next, w_final_cmd;
  logic [PARAM_W-1:0] r_par1, r_par2, w_par1_next, w_par2_next;
  logic [PARAM_W-1:0] w_def_par1, w_def_par2, w_cnt1, w_cnt2;
  logic [7:0]         r_char, w_char_next, w_byte;
  logic               r_discard, w_discard_next;
  logic               w_clear, w_dig1, w_dig2, w_take_final;
  logic [PARAM_W-1:0] w_acc1, w_acc2;
  logic               w_pres1, w_pres2;
  logic               w_is_digit;

  assign w_byte      = bus.in_data;
  assign w_is_digit  = (w_byte >= 8'h30) && (w_byte <= 8'h39);
  assign w_final_cmd = decode_final(w_byte);

  dec_param_acc #(.PARAM_W(PARAM_W)) u_acc1 (
    .clk(clk), .rst(rst), .i_clear(w_clear), .i_digit_valid(w_dig1),
    .i_digit(w_byte[3:0]), .o_value(w_acc1), .o_present(w_pres1)
  );

  dec_param_acc #(.PARAM_W(PARAM_W)) u_acc2 (
    .clk(clk), .rst(rst), .i_clear(w_clear), .i_digit_valid(w_dig2),
    .i_digit(w_byte[3:0]), .o_value(w_acc2), .o_present(w_pres2)
  );

  assign w_cnt1 = (w_pres1 && (w_acc1 != '0)) ? w_acc1 : ONE;
  assign w_cnt2 = (w_pres2 && (w_acc2 != '0)) ? w_acc2 : ONE;

  // Apply per-command parameter defaults to the accumulated values
  always_comb begin
    w_def_par1 = '0;
    w_def_par2 = '0;
    case (w_final_cmd)
      CMD_CUF, CMD_CUB, CMD_CNL, CMD_CPL, CMD_CHA, CMD_SU, CMD_SD:
        w_def_par1 = w_cnt1;
      CMD_CUP, CMD_HVP: begin
        w_def_par1 = w_cnt1;
        w_def_par2 = w_cnt2;
      end
      CMD_ED, CMD_EL:
        w_def_par1 = w_pres1 ? w_acc1 : '0;
      default: ;
    endcase
  end

  // Next-state, accumulator control and pending-event selection
  always_comb begin
    w_state_next   = r_state;
    w_cmd_next     = r_cmd;
    w_par1_next    = r_par1;
    w_par2_next    = r_par2;
    w_char_next    = r_char;
    w_discard_next = r_discard;
    w_clear        = 1'b0;
    w_dig1         = 1'b0;
    w_dig2         = 1'b0;
    w_take_final   = 1'b0;

    if (r_state == ST_HOLD) begin
      if (bus.out_ready) begin
        w_state_next = ST_GROUND;
        w_cmd_next   = CMD_NONE;
        w_par1_next  = '0;
        w_par2_next  = '0;
        w_char_next  = '0;
      end
    end else if (bus.in_valid) begin
      if ((w_byte == CAN) || (w_byte == SUB)) begin
        w_state_next = ST_GROUND;
      end else if (w_byte == ESC) begin
        w_state_next = ST_ESC;
      end else begin
        case (r_state)
          ST_GROUND: begin
            if ((w_byte == BS) || (w_byte == DEL)) begin
              w_cmd_next   = CMD_DELETE;
              w_state_next = ST_HOLD;
            end else if ((w_byte >= 8'h20) && (w_byte <= 8'h7E)) begin
              w_cmd_next   = CMD_CHAR;
              w_char_next  = w_byte;
              w_state_next = ST_HOLD;
            end
          end
          ST_ESC: begin
            if (w_byte == CSI_INTRO) begin
              w_state_next   = ST_CSI_P1;
              w_clear        = 1'b1;
              w_discard_next = 1'b0;
            end else if (w_byte == FIN_CLEAR) begin
              w_cmd_next   = CMD_CLEAR;
              w_state_next = ST_HOLD;
            end else if (w_byte == FIN_UNAME) begin
              w_cmd_next   = CMD_UNAME;
              w_state_next = ST_HOLD;
            end else begin
              w_state_next = ST_GROUND;
            end
          end
          ST_CSI_P1, ST_CSI_P2: begin
            if (w_is_digit) begin
              w_dig1 = (r_state == ST_CSI_P1);
              w_dig2 = (r_state == ST_CSI_P2);
            end else if (w_byte == SEMI) begin
              w_state_next = (r_state == ST_CSI_P1) ? ST_CSI_P2 : ST_CSI_IGN;
            end else if (((w_byte >= 8'h20) && (w_byte <= 8'h2F)) ||
                         ((w_byte >= 8'h3C) && (w_byte <= 8'h3F))) begin
              w_state_next   = ST_CSI_IGN;
              w_discard_next = 1'b1;
            end else if ((w_byte >= 8'h40) && (w_byte <= 8'h7E)) begin
              w_take_final = 1'b1;
            end
          end
          ST_CSI_IGN: begin
            if ((w_byte >= 8'h40) && (w_byte <= 8'h7E)) begin
              if (r_discard) w_state_next = ST_GROUND;
              else           w_take_final = 1'b1;
            end
          end
          default: w_state_next = ST_GROUND;
        endcase
      end

      if (w_take_final) begin
        if (w_final_cmd == CMD_NONE) begin
          w_state_next = ST_GROUND;
        end else begin
          w_state_next = ST_HOLD;
          w_cmd_next   = w_final_cmd;
          w_par1_next  = w_def_par1;
          w_par2_next  = w_def_par2;
          w_char_next  = '0;
        end
      end
    end
  end

  // State and registered output event; reset drops anything pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_GROUND;
      r_cmd     <= CMD_NONE;
      r_par1    <= '0;
      r_par2    <= '0;
      r_char    <= '0;
      r_discard <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cmd     <= w_cmd_next;
      r_par1    <= w_par1_next;
      r_par2    <= w_par2_next;
      r_char    <= w_char_next;
      r_discard <= w_discard_next;
    end
  end

  assign bus.in_ready   = (r_state != ST_HOLD);
  assign bus.Delete     = (r_cmd == CMD_DELETE);
  assign bus.CUF        = (r_cmd == CMD_CUF);
  assign bus.CUB        = (r_cmd == CMD_CUB);
  assign bus.CNL        = (r_cmd == CMD_CNL);
  assign bus.CPL        = (r_cmd == CMD_CPL);
  assign bus.CHA        = (r_cmd == CMD_CHA);
  assign bus.CUP        = (r_cmd == CMD_CUP);
  assign bus.ED         = (r_cmd == CMD_ED);
  assign bus.EL         = (r_cmd == CMD_EL);
  assign bus.SU         = (r_cmd == CMD_SU);
  assign bus.SD         = (r_cmd == CMD_SD);
  assign bus.HVP        = (r_cmd == CMD_HVP);
  assign bus.SCP        = (r_cmd == CMD_SCP);
  assign bus.RCP        = (r_cmd == CMD_RCP);
  assign bus.Clear      = (r_cmd == CMD_CLEAR);
  assign bus.Uname      = (r_cmd == CMD_UNAME);
  assign bus.char_valid = (r_cmd == CMD_CHAR);
  assign bus.par1       = r_par1;
  assign bus.par2       = r_par2;
  assign bus.char_data  = r_char;
endmodule

// File: tb/tb_ansi_cmd_parser.sv
// Directed bench for ansi_cmd_parser: one task per scenario with inline checks.
module tb_ansi_cmd_parser;
  localparam int EV_DELETE = 0,  EV_CUF = 1,  EV_CUB = 2,   EV_CNL = 3,  EV_CPL = 4;
  localparam int EV_CHA    = 5,  EV_CUP = 6,  EV_ED  = 7,   EV_EL  = 8,  EV_SU  = 9;
  localparam int EV_SD     = 10, EV_HVP = 11, EV_SCP = 12,  EV_RCP = 13, EV_CLEAR = 14;
  localparam int EV_UNAME  = 15, EV_CHAR = 16;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  ansi_cmd_parser_if #(.PARAM_W(8)) bus ();

  ansi_cmd_parser #(.PARAM_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Absolute time limit so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Collect all event outputs into one vector, bit order as EV_* above
  function automatic logic [16:0] get_events();
    return {bus.char_valid, bus.Uname, bus.Clear, bus.RCP, bus.SCP, bus.HVP,
            bus.SD, bus.SU, bus.EL, bus.ED, bus.CUP, bus.CHA, bus.CPL,
            bus.CNL, bus.CUB, bus.CUF, bus.Delete};
  endfunction

  // Present one byte and return #1 after the edge that accepted it
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL send_wait actual in_ready=0 required=1 byte=%02h", b);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // ESC followed by the characters of s
  task automatic send_esc(input string s);
    send_byte(8'h1B);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic test_reset();
    total++;
    if (get_events() !== 17'd0 || bus.in_ready !== 1'b1 || bus.par1 !== 8'd0 ||
        bus.par2 !== 8'd0 || bus.char_data !== 8'd0) begin
      bad++;
      $display("[TB] FAIL reset_state actual ev=%h rdy=%b p1=%0d p2=%0d ch=%h required ev=0 rdy=1 p1=0 p2=0 ch=0",
               get_events(), bus.in_ready, bus.par1, bus.par2, bus.char_data);
    end
  endtask

  task automatic test_cup();
    bus.out_ready = 1'b1;
    send_esc("[12;34H");
    total++;
    if (get_events() !== (17'(1) << EV_CUP) || bus.par1 !== 8'd12 || bus.par2 !== 8'd34 ||
        bus.in_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL cup_event actual ev=%h p1=%0d p2=%0d rdy=%b required ev=%h p1=12 p2=34 rdy=0",
               get_events(), bus.par1, bus.par2, bus.in_ready, 17'(1) << EV_CUP);
    end
    @(posedge clk);
    #1;
    total++;
    if (get_events() !== 17'd0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL cup_release actual ev=%h rdy=%b required ev=0 rdy=1",
               get_events(), bus.in_ready);
    end
  endtask

  task automatic test_params();
    string seqs[12] = '{"[C", "[0D", "[2J", "[K", "[7;f", "[s", "[3u", "[E", "[5F",
                        "[999G", "[300;256H", "[255;1;9H"};
    int    evs[12]  = '{EV_CUF, EV_CUB, EV_ED, EV_EL, EV_HVP, EV_SCP, EV_RCP, EV_CNL, EV_CPL,
                        EV_CHA, EV_CUP, EV_CUP};
    int    p1s[12]  = '{1, 1, 2, 0, 7, 0, 0, 1, 5, 255, 255, 255};
    int    p2s[12]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 255, 1};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send_esc(seqs[i]);
      total++;
      if (get_events() !== (17'(1) << evs[i]) || bus.par1 !== 8'(p1s[i]) ||
          bus.par2 !== 8'(p2s[i])) begin
        bad++;
        $display("[TB] FAIL param_%0d actual ev=%h p1=%0d p2=%0d required ev=%h p1=%0d p2=%0d",
                 i, get_events(), bus.par1, bus.par2, 17'(1) << evs[i], p1s[i], p2s[i]);
      end
      @(posedge clk);
      #1;
      total++;
      if (get_events() !== 17'd0 || bus.in_ready !== 1'b1) begin
        bad++;
        $display("[TB] FAIL param_%0d_release actual ev=%h rdy=%b required ev=0 rdy=1",
                 i, get_events(), bus.in_ready);
      end
    end
  endtask

  task automatic test_discard();
    bus.out_ready = 1'b1;
    send_esc("[?25h");
    total++;
    if (get_events() !== 17'd0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL private_discard actual ev=%h rdy=%b required ev=0 rdy=1",
               get_events(), bus.in_ready);
    end
    send_esc("[5A");
    total++;
    if (get_events() !== 17'd0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL unmapped_final actual ev=%h rdy=%b required ev=0 rdy=1",
               get_events(), bus.in_ready);
    end
    send_esc("[3");
    send_byte(8'h18);
    total++;
    if (get_events() !== 17'd0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL can_abort actual ev=%h rdy=%b required ev=0 rdy=1",
               get_events(), bus.in_ready);
    end
    send_byte(8'h43);
    total++;
    if (get_events() !== (17'(1) << EV_CHAR) || bus.char_data !== 8'h43) begin
      bad++;
      $display("[TB] FAIL after_can_char actual ev=%h ch=%h required ev=%h ch=43",
               get_events(), bus.char_data, 17'(1) << EV_CHAR);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_hold();
    bus.out_ready = 1'b0;
    send_byte(8'h61);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h1B;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bus.char_valid !== 1'b1 || bus.char_data !== 8'h61 || bus.in_ready !== 1'b0 ||
          get_events() !== (17'(1) << EV_CHAR)) begin
        bad++;
        $display("[TB] FAIL hold_cycle_%0d actual cv=%b ch=%h rdy=%b ev=%h required cv=1 ch=61 rdy=0",
                 i, bus.char_valid, bus.char_data, bus.in_ready, get_events());
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    total++;
    if (get_events() !== 17'd0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL hold_release actual ev=%h rdy=%b required ev=0 rdy=1",
               get_events(), bus.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes[4] = '{8'h63, 8'h5A, 8'h7F, 8'h08};
    int         evs[4]   = '{EV_CLEAR, EV_UNAME, EV_DELETE, EV_DELETE};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i < 2) send_byte(8'h1B);
      send_byte(bytes[i]);
      total++;
      if (get_events() !== (17'(1) << evs[i]) || bus.par1 !== 8'd0 || bus.par2 !== 8'd0) begin
        bad++;
        $display("[TB] FAIL b2b_%0d actual ev=%h p1=%0d p2=%0d required ev=%h p1=0 p2=0",
                 i, get_events(), bus.par1, bus.par2, 17'(1) << evs[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_in_hold();
    bus.out_ready = 1'b0;
    send_esc("[4S");
    total++;
    if (get_events() !== (17'(1) << EV_SU) || bus.par1 !== 8'd4 || bus.par2 !== 8'd0) begin
      bad++;
      $display("[TB] FAIL su_pending actual ev=%h p1=%0d p2=%0d required ev=%h p1=4 p2=0",
               get_events(), bus.par1, bus.par2, 17'(1) << EV_SU);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (get_events() !== 17'd0 || bus.in_ready !== 1'b1 || bus.par1 !== 8'd0 ||
        bus.par2 !== 8'd0 || bus.char_data !== 8'd0) begin
      bad++;
      $display("[TB] FAIL reset_in_hold actual ev=%h rdy=%b p1=%0d required ev=0 rdy=1 p1=0",
               get_events(), bus.in_ready, bus.par1);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    send_byte(8'h78);
    total++;
    if (get_events() !== (17'(1) << EV_CHAR) || bus.char_data !== 8'h78) begin
      bad++;
      $display("[TB] FAIL post_reset_char actual ev=%h ch=%h required ev=%h ch=78",
               get_events(), bus.char_data, 17'(1) << EV_CHAR);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_cup();
    test_params();
    test_discard();
    test_hold();
    test_back_to_back();
    test_reset_in_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
